sp_ram_stream_loader: RTL and testbench

Bus initiator that drives the single-port RAM wrapper port (en/addr/wdata/we/be, rdata one cycle after a read).
- Load mode: accepts a byte stream (valid/ready), packs it little-endian into 32-bit words and writes them to consecutive RAM words.
- Dump mode: reads consecutive RAM words and emits them as a byte stream, LSB first.
- Used for boot-time program loading and memory dump over a byte link (UART/JTAG bridge).

---
 rtl/sp_ram_stream_loader.sv | 178 +++++++++++++++++
 tb/tb_sp_ram_stream_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_stream_loader.sv
// Byte-stream <-> single-port RAM transfer engine.
// Load mode packs an incoming byte stream little-endian into 32-bit words
// and writes them to consecutive word addresses. Dump mode reads consecutive
// words and emits them as a byte stream, least significant byte first.
module sp_ram_stream_loader #(
  parameter int RAM_SIZE   = 32768,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = ADDR_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_words_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_COLLECT,
    S_LD_WRITE,
    S_DP_READ,
    S_DP_CAPTURE,
    S_DP_SEND,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic [LEN_WIDTH-1:0]  idx_inc;
  logic [ADDR_WIDTH-1:0] word_addr;

  // Word address wraps modulo the RAM size; the extra top bit of idx*4 is dropped.
  always_comb begin
    idx_inc   = idx_q + LEN_WIDTH'(1);
    word_addr = base_q + ADDR_WIDTH'({idx_q, 2'b00});
  end

  // State and datapath registers; everything clears on reset so a partial word is discarded.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      base_q     <= '0;
      byte_cnt_q <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      base_q     <= base_d;
      byte_cnt_q <= byte_cnt_d;
      data_q     <= data_d;
    end
  end

  // Next-state logic and all outputs; outputs depend only on registered state,
  // so they are held stable across stream stalls.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    base_d      = base_q;
    byte_cnt_d  = byte_cnt_q;
    data_d      = data_q;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    rx_ready_o  = 1'b0;
    tx_valid_o  = 1'b0;
    tx_data_o   = 8'h00;
    ram_en_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = 4'h0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          // Low address bits are forced to zero so every access is word aligned.
          base_d     = base_addr_i & ~ADDR_WIDTH'(3);
          len_d      = len_words_i;
          idx_d      = '0;
          byte_cnt_d = '0;
          data_d     = '0;
          if (len_words_i == '0) begin
            state_d = S_DONE;
          end else if (mode_i) begin
            state_d = S_DP_READ;
          end else begin
            state_d = S_LD_COLLECT;
          end
        end
      end

      S_LD_COLLECT: begin
        busy_o     = 1'b1;
        rx_ready_o = 1'b1;
        if (rx_valid_i) begin
          data_d[{byte_cnt_q, 3'b000} +: 8] = rx_data_i;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = S_LD_WRITE;
          end
        end
      end

      S_LD_WRITE: begin
        busy_o      = 1'b1;
        ram_en_o    = 1'b1;
        ram_we_o    = 1'b1;
        ram_be_o    = 4'hF;
        ram_addr_o  = word_addr;
        ram_wdata_o = data_q;
        idx_d       = idx_inc;
        state_d     = (idx_inc == len_q) ? S_DONE : S_LD_COLLECT;
      end

      S_DP_READ: begin
        busy_o     = 1'b1;
        ram_en_o   = 1'b1;
        ram_addr_o = word_addr;
        state_d    = S_DP_CAPTURE;
      end

      S_DP_CAPTURE: begin
        busy_o     = 1'b1;
        data_d     = ram_rdata_i;
        byte_cnt_d = '0;
        state_d    = S_DP_SEND;
      end

      S_DP_SEND: begin
        busy_o     = 1'b1;
        tx_valid_o = 1'b1;
        tx_data_o  = data_q[{byte_cnt_q, 3'b000} +: 8];
        if (tx_ready_i) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            idx_d   = idx_inc;
            state_d = (idx_inc == len_q) ? S_DONE : S_DP_READ;
          end
        end
      end

      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sp_ram_stream_loader.sv
// Testbench for sp_ram_stream_loader: table of transfers plus a reset-abort sequence,
// with a RAM model and scoreboards for RAM writes and dumped bytes.
module tb_sp_ram_stream_loader;

  localparam int AW = 15;
  localparam int LW = 14;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] base = '0;
  logic [LW-1:0] len = '0;
  logic          busy_o, done_o;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready_o;
  logic [7:0]    tx_data_o;
  logic          tx_valid_o;
  logic          tx_ready = 1'b0;
  logic          ram_en_o;
  logic [AW-1:0] ram_addr_o;
  logic [31:0]   ram_wdata_o;
  logic [31:0]   ram_rdata = '0;
  logic          ram_we_o;
  logic [3:0]    ram_be_o;

  always #5 clk = ~clk;

  sp_ram_stream_loader #(.RAM_SIZE(32768)) dut (
    .clk(clk), .rstn_i(rstn), .start_i(start), .mode_i(mode),
    .base_addr_i(base), .len_words_i(len), .busy_o(busy_o), .done_o(done_o),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready),
    .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // RAM model with one-cycle read latency
  logic [31:0] mem [8192];
  logic [31:0] shadow [8192];

  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b]) mem[ram_addr_o[14:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr_o[14:2]];
      end
    end
  end

  int unsigned cyc_cnt = 0;
  always @(posedge clk) cyc_cnt++;

  // Scoreboards and monitors
  logic [46:0] exp_wr [$];
  logic [7:0]  exp_tx [$];
  int          en_cnt = 0, rdy_cnt = 0, tv_cnt = 0;
  int unsigned last_wr_cyc = 0;
  logic        stall_prev = 1'b0;
  logic [7:0]  stall_byte = '0;

  always begin
    @(negedge clk);
    #2;
    if (!rstn) begin
      stall_prev = 1'b0;
    end else begin
      if (ram_en_o) en_cnt++;
      if (rx_ready_o) rdy_cnt++;
      if (tx_valid_o) tv_cnt++;
      if (ram_en_o && ram_we_o) begin
        last_wr_cyc = cyc_cnt;
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", {17'd0, ram_addr_o, ram_wdata_o}, 64'd0);
        end else begin
          logic [46:0] e;
          e = exp_wr.pop_front();
          chk("wr_addr", 64'(ram_addr_o), 64'(e[46:32]));
          chk("wr_data", 64'(ram_wdata_o), 64'(e[31:0]));
          chk("wr_be", 64'(ram_be_o), 64'hF);
        end
      end
      if (ram_en_o && !ram_we_o) chk("rd_be_wdata", {28'd0, ram_be_o, ram_wdata_o}, 64'd0);
      if (stall_prev) chk("tx_hold", {55'd0, tx_valid_o, tx_data_o}, {55'd0, 1'b1, stall_byte});
      stall_prev = tx_valid_o && !tx_ready;
      stall_byte = tx_data_o;
      if (tx_valid_o && tx_ready) begin
        if (exp_tx.size() == 0) begin
          chk("unexpected_tx", 64'(tx_data_o), 64'hFFFF);
        end else begin
          logic [7:0] eb;
          eb = exp_tx.pop_front();
          chk("tx_byte", 64'(tx_data_o), 64'(eb));
        end
      end
    end
  end

  typedef struct {
    logic          mode;
    logic [AW-1:0] base;
    int            len;
    logic [31:0]   w0;
    logic [31:0]   w1;
    bit            tog;
    bit            pulse;
  } vec_t;

  task automatic run(input vec_t v);
    logic [31:0] wv [2];
    int          n, bi, en0, rd0, tv0, a;
    bit          got;
    int unsigned done_cyc;
    wv[0] = v.w0;
    wv[1] = v.w1;
    n = v.len * 4;
    bi = 0;
    got = 1'b0;
    done_cyc = 0;
    for (int i = 0; i < v.len; i++) begin
      a = ((int'(v.base) & 32'h7FFC) + 4 * i) & 32'h7FFF;
      if (!v.mode) begin
        exp_wr.push_back({15'(a), wv[i]});
        shadow[a >> 2] = wv[i];
      end else begin
        for (int k = 0; k < 4; k++) exp_tx.push_back(shadow[a >> 2][8*k +: 8]);
      end
    end
    en0 = en_cnt; rd0 = rdy_cnt; tv0 = tv_cnt;
    @(negedge clk);
    start = 1'b1; mode = v.mode; base = v.base; len = LW'(v.len);
    @(negedge clk);
    for (int cyc = 0; cyc < 600 && !got; cyc++) begin
      if (cyc == 0) begin
        mode = ~v.mode; base = 15'h5555; len = 14'd3;
      end
      if (v.pulse && cyc == 3) begin
        start = 1'b1; mode = ~v.mode; base = 15'h400; len = 14'd1;
      end else begin
        start = 1'b0;
      end
      rx_valid = !v.mode && (bi < n);
      rx_data  = (bi < n) ? wv[bi / 4][8 * (bi % 4) +: 8] : 8'h00;
      if (rx_valid && rx_ready_o) bi++;
      tx_ready = v.tog ? ((cyc % 2) == 1) : 1'b1;
      #2;
      if (cyc == 0) chk("start_resp", {62'd0, busy_o, done_o}, {62'd0, v.len != 0, v.len == 0});
      if (done_o) begin
        got = 1'b1;
        done_cyc = cyc_cnt;
      end else begin
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk("done_seen", 64'(got), 64'd1);
    if (!v.mode && v.len != 0) chk("done_after_last_wr", 64'(done_cyc - last_wr_cyc), 64'd1);
    @(negedge clk);
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    #2;
    chk("done_pulse_busy", {62'd0, done_o, busy_o}, 64'd0);
    chk("queues_empty", 64'(exp_wr.size() + exp_tx.size()), 64'd0);
    chk("ram_en_cycles", 64'(en_cnt - en0), 64'(v.len));
    if (v.len == 0) chk("stream_idle", 64'((rdy_cnt - rd0) + (tv_cnt - tv0)), 64'd0);
  endtask

  vec_t vecs [11];

  initial begin
    vec_t vr;
    int   en0;
    for (int i = 0; i < 8192; i++) begin
      mem[i] = '0;
      shadow[i] = '0;
    end
    vecs[0]  = '{1'b0, 15'h100,  2, 32'h44332211, 32'h88776655, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 15'h100,  2, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[2]  = '{1'b1, 15'h100,  2, 32'h0,        32'h0,        1'b1, 1'b1};
    vecs[3]  = '{1'b0, 15'h7FFC, 2, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 15'h103,  1, 32'h0BADC0DE, 32'h0,        1'b0, 1'b0};
    vecs[5]  = '{1'b1, 15'h7FFC, 2, 32'h0,        32'h0,        1'b1, 1'b0};
    vecs[6]  = '{1'b1, 15'h100,  1, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[7]  = '{1'b0, 15'h000,  0, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[8]  = '{1'b1, 15'h000,  0, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[9]  = '{1'b0, 15'h300,  2, 32'h13579BDF, 32'h2468ACE0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 15'h300,  2, 32'h0,        32'h0,        1'b1, 1'b0};

    repeat (3) @(negedge clk);
    #2;
    chk("reset_ctrl", {53'd0, busy_o, done_o, rx_ready_o, tx_valid_o, tx_data_o, ram_en_o, ram_we_o, ram_be_o},
        64'd0);
    chk("reset_bus", {17'd0, ram_addr_o, ram_wdata_o}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 11; i++) run(vecs[i]);

    // Reset in the middle of collecting a word: nothing may be written
    en0 = en_cnt;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; base = 15'h200; len = 14'd1;
    @(negedge clk);
    start = 1'b0; rx_valid = 1'b1; rx_data = 8'hE1;
    @(negedge clk);
    rx_data = 8'hE2;
    @(negedge clk);
    rx_data = 8'hE3;
    #3;
    rstn = 1'b0;
    #1;
    chk("abort_ctrl", {53'd0, busy_o, done_o, rx_ready_o, tx_valid_o, tx_data_o, ram_en_o, ram_we_o, ram_be_o},
        64'd0);
    chk("abort_bus", {17'd0, ram_addr_o, ram_wdata_o}, 64'd0);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    chk("abort_no_write", 64'(en_cnt - en0), 64'd0);
    chk("abort_ram_kept", 64'(mem[15'h200 >> 2]), 64'd0);

    vr = '{1'b0, 15'h200, 1, 32'hA4A3A2A1, 32'h0, 1'b0, 1'b0};
    run(vr);
    vr = '{1'b1, 15'h200, 1, 32'h0, 32'h0, 1'b1, 1'b0};
    run(vr);
    chk("ram_0x100", 64'(mem[15'h100 >> 2]), 64'h0BADC0DE);
    chk("ram_0x000", 64'(mem[0]), 64'hCAFEF00D);
    chk("ram_0x400_untouched", 64'(mem[15'h400 >> 2]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
